// File: rtl/estagio_wb_banco.sv
// estagio_wb_banco
// Write-back end of the 16-bit pipeline: selects the ALU or data-memory
// result offered by execute/memory, holds it in a one-entry WB stage
// register, commits it into the general-purpose register bank and counts
// committed entries. Two combinational read ports (A, B) serve decode,
// with bypass from the pending WB entry. R0 always reads as zero.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   valido_in / pronto_out  offer/accept handshake (pronto_out = !congelar)
//   congelar                freeze: hold WB stage, no capture, no commit
//   MUX_WB_sel              0 = Saida_ULA, 1 = Saida_MemoriaDados
//   BR_Hab_Escrita          offered result writes the bank
//   rd_endereco             destination register of the offer
//   ra_endereco/A           read port A
//   rb_endereco/B           read port B
//   wb_pendente             WB stage holds a valid, write-enabled, non-R0 entry
//   instrucoes_retiradas    committed-entry counter (wraps)
module estagio_wb_banco #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_REGS = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valido_in,
  output logic              pronto_out,
  input  logic              congelar,
  input  logic              MUX_WB_sel,
  input  logic              BR_Hab_Escrita,
  input  logic [ADDR_W-1:0] rd_endereco,
  input  logic [DATA_W-1:0] Saida_ULA,
  input  logic [DATA_W-1:0] Saida_MemoriaDados,
  input  logic [ADDR_W-1:0] ra_endereco,
  input  logic [ADDR_W-1:0] rb_endereco,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              wb_pendente,
  output logic [15:0]       instrucoes_retiradas
);

  logic              wb_valido;
  logic              wb_hab;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_dado;
  logic [DATA_W-1:0] banco [N_REGS];
  logic [15:0]       contador;

  assign pronto_out           = !congelar;
  assign instrucoes_retiradas = contador;
  assign wb_pendente          = wb_valido && wb_hab && (wb_rd != '0);

  // Commit of the held entry and capture of a new offer share the same
  // edge, giving one entry per cycle; the freeze gates both together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      banco     <= '{default: '0};
      wb_valido <= 1'b0;
      wb_hab    <= 1'b0;
      wb_rd     <= '0;
      wb_dado   <= '0;
      contador  <= '0;
    end else if (!congelar) begin
      if (wb_valido) begin
        if (wb_hab && (wb_rd != '0)) begin
          banco[wb_rd] <= wb_dado;
        end
        contador <= contador + 16'd1;
      end
      wb_valido <= valido_in;
      if (valido_in) begin
        wb_hab  <= BR_Hab_Escrita;
        wb_rd   <= rd_endereco;
        wb_dado <= MUX_WB_sel ? Saida_MemoriaDados : Saida_ULA;
      end
    end
  end

  // Read ports: R0 is hard zero, then bypass from the pending entry,
  // then the bank contents.
  always_comb begin
    A = '0;
    if (ra_endereco != '0) begin
      if (wb_valido && wb_hab && (wb_rd == ra_endereco)) begin
        A = wb_dado;
      end else begin
        A = banco[ra_endereco];
      end
    end
  end

  always_comb begin
    B = '0;
    if (rb_endereco != '0) begin
      if (wb_valido && wb_hab && (wb_rd == rb_endereco)) begin
        B = wb_dado;
      end else begin
        B = banco[rb_endereco];
      end
    end
  end

endmodule

// File: tb/tb_estagio_wb_banco.sv
module tb_estagio_wb_banco;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valido_in;
  logic        pronto_out;
  logic        congelar;
  logic        MUX_WB_sel;
  logic        BR_Hab_Escrita;
  logic [3:0]  rd_endereco;
  logic [15:0] Saida_ULA;
  logic [15:0] Saida_MemoriaDados;
  logic [3:0]  ra_endereco;
  logic [3:0]  rb_endereco;
  logic [15:0] A;
  logic [15:0] B;
  logic        wb_pendente;
  logic [15:0] instrucoes_retiradas;

  always #5 clock = ~clock;

  estagio_wb_banco #(.DATA_W(16), .N_REGS(16), .ADDR_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .valido_in(valido_in),
    .pronto_out(pronto_out), .congelar(congelar), .MUX_WB_sel(MUX_WB_sel),
    .BR_Hab_Escrita(BR_Hab_Escrita), .rd_endereco(rd_endereco),
    .Saida_ULA(Saida_ULA), .Saida_MemoriaDados(Saida_MemoriaDados),
    .ra_endereco(ra_endereco), .rb_endereco(rb_endereco),
    .A(A), .B(B), .wb_pendente(wb_pendente),
    .instrucoes_retiradas(instrucoes_retiradas)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_total++;
    if (atual === esperado) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nome, atual, esperado, $time);
  endtask

  // Reference model: register file as an array, in-flight results as a queue
  // of accepted offers waiting for their commit edge, plus a commit tally.
  typedef struct {
    logic       hab;
    logic [3:0] rd;
    logic [15:0] dado;
  } ent_t;

  logic [15:0] m_banco [16];
  ent_t        m_fila [$];
  logic [15:0] m_cnt;

  task automatic m_reset();
    foreach (m_banco[i]) m_banco[i] = 16'h0000;
    m_fila.delete();
    m_cnt = 16'h0000;
  endtask

  function automatic logic [15:0] m_ler(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (m_fila.size() != 0 && m_fila[0].hab && m_fila[0].rd == a) return m_fila[0].dado;
    return m_banco[a];
  endfunction

  function automatic logic m_pend();
    return (m_fila.size() != 0) && m_fila[0].hab && (m_fila[0].rd != 4'd0);
  endfunction

  task automatic m_borda();
    ent_t e;
    if (!reset_n || congelar) return;
    if (m_fila.size() != 0) begin
      e = m_fila.pop_front();
      if (e.hab && e.rd != 4'd0) m_banco[e.rd] = e.dado;
      m_cnt = m_cnt + 16'd1;
    end
    if (valido_in) begin
      e.hab  = BR_Hab_Escrita;
      e.rd   = rd_endereco;
      e.dado = MUX_WB_sel ? Saida_MemoriaDados : Saida_ULA;
      m_fila.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    m_borda();
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic s, input logic h,
                       input logic [3:0] rd, input logic [15:0] ula, input logic [15:0] mem,
                       input logic [3:0] ra, input logic [3:0] rb);
    valido_in = v; congelar = c; MUX_WB_sel = s; BR_Hab_Escrita = h;
    rd_endereco = rd; Saida_ULA = ula; Saida_MemoriaDados = mem;
    ra_endereco = ra; rb_endereco = rb;
  endtask

  task automatic chk_model(input string nome);
    chk({nome, ".A"}, {16'h0, A}, {16'h0, m_ler(ra_endereco)});
    chk({nome, ".B"}, {16'h0, B}, {16'h0, m_ler(rb_endereco)});
    chk({nome, ".pend"}, {31'h0, wb_pendente}, {31'h0, m_pend()});
    chk({nome, ".cnt"}, {16'h0, instrucoes_retiradas}, {16'h0, m_cnt});
    chk({nome, ".pronto"}, {31'h0, pronto_out}, {31'h0, !congelar});
  endtask

  typedef struct {
    logic v; logic sel; logic hab; logic [3:0] rd;
    logic [15:0] ula; logic [15:0] mem; logic [3:0] ra; logic [3:0] rb;
    logic [15:0] e_a; logic [15:0] e_b; logic e_pend; logic [15:0] e_cnt;
  } vec_t;

  vec_t tab [7];

  initial begin
    // Each row: inputs applied, one clock edge, then outputs checked.
    tab[0] = '{1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 16'h0000, 4'd5, 4'd0, 16'h1234, 16'h0000, 1'b1, 16'd0};
    tab[1] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd5, 4'd5, 16'h1234, 16'h1234, 1'b0, 16'd1};
    tab[2] = '{1'b1, 1'b1, 1'b1, 4'd2, 16'h0000, 16'hBEEF, 4'd5, 4'd2, 16'h1234, 16'hBEEF, 1'b1, 16'd1};
    tab[3] = '{1'b1, 1'b0, 1'b1, 4'd2, 16'h0042, 16'hDEAD, 4'd2, 4'd2, 16'h0042, 16'h0042, 1'b1, 16'd2};
    tab[4] = '{1'b1, 1'b0, 1'b1, 4'd0, 16'hFFFF, 16'h0000, 4'd0, 4'd2, 16'h0000, 16'h0042, 1'b0, 16'd3};
    tab[5] = '{1'b1, 1'b0, 1'b0, 4'd7, 16'h5555, 16'h0000, 4'd7, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'd4};
    tab[6] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd7, 4'd2, 16'h0000, 16'h0042, 1'b0, 16'd5};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd1, 4'd2);
    m_reset();
    #12;
    chk("rst.A", {16'h0, A}, 32'h0);
    chk("rst.B", {16'h0, B}, 32'h0);
    chk("rst.pend", {31'h0, wb_pendente}, 32'h0);
    chk("rst.cnt", {16'h0, instrucoes_retiradas}, 32'h0);
    chk("rst.pronto", {31'h0, pronto_out}, 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed table: ALU write + bypass, memory select back-to-back, R0 / no-write.
    for (int i = 0; i < 7; i++) begin
      drive(tab[i].v, 1'b0, tab[i].sel, tab[i].hab, tab[i].rd, tab[i].ula, tab[i].mem,
            tab[i].ra, tab[i].rb);
      tick();
      chk($sformatf("tab%0d.A", i), {16'h0, A}, {16'h0, tab[i].e_a});
      chk($sformatf("tab%0d.B", i), {16'h0, B}, {16'h0, tab[i].e_b});
      chk($sformatf("tab%0d.pend", i), {31'h0, wb_pendente}, {31'h0, tab[i].e_pend});
      chk($sformatf("tab%0d.cnt", i), {16'h0, instrucoes_retiradas}, {16'h0, tab[i].e_cnt});
    end

    // Freeze: R4 held while R6 is offered and refused.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 16'hA5A5, 16'h0, 4'd4, 4'd6);
    tick();
    chk("frz0.A", {16'h0, A}, 32'hA5A5);
    chk("frz0.pend", {31'h0, wb_pendente}, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 16'h1111, 16'h0, 4'd4, 4'd6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("frz%0d.pronto", k + 1), {31'h0, pronto_out}, 32'h0);
      chk($sformatf("frz%0d.A", k + 1), {16'h0, A}, 32'hA5A5);
      chk($sformatf("frz%0d.B", k + 1), {16'h0, B}, 32'h0);
      chk($sformatf("frz%0d.cnt", k + 1), {16'h0, instrucoes_retiradas}, 32'd5);
      chk($sformatf("frz%0d.pend", k + 1), {31'h0, wb_pendente}, 32'h1);
    end
    congelar = 1'b0;
    tick();
    chk("frz_rel.cnt", {16'h0, instrucoes_retiradas}, 32'd6);
    chk("frz_rel.A", {16'h0, A}, 32'hA5A5);
    chk("frz_rel.B", {16'h0, B}, 32'h1111);
    valido_in = 1'b0;
    tick();
    chk("frz_end.cnt", {16'h0, instrucoes_retiradas}, 32'd7);
    chk("frz_end.B", {16'h0, B}, 32'h1111);
    chk("frz_end.pend", {31'h0, wb_pendente}, 32'h0);

    // Asynchronous reset with R3 pending.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'h7777, 16'h0, 4'd3, 4'd4);
    tick();
    chk("rst2.pre_A", {16'h0, A}, 32'h7777);
    valido_in = 1'b0;
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst2.A", {16'h0, A}, 32'h0);
    chk("rst2.B", {16'h0, B}, 32'h0);
    chk("rst2.cnt", {16'h0, instrucoes_retiradas}, 32'h0);
    chk("rst2.pend", {31'h0, wb_pendente}, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();
    chk("rst2.after_A", {16'h0, A}, 32'h0);
    chk("rst2.after_cnt", {16'h0, instrucoes_retiradas}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), 1'($urandom),
            1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 4'($urandom));
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    // Counter wrap: continuous commits until the tally reaches 0xFFFF.
    reset_n = 1'b0;
    m_reset();
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 4'd0);
    for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) tick();
    chk("wrap.pre", {16'h0, instrucoes_retiradas}, 32'hFFFF);
    tick();
    chk("wrap.post", {16'h0, instrucoes_retiradas}, 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
